// File: rtl/neuron_seq_sched_if.sv
// Interface bundling the sample, result and config buses of neuron_seq_sched.
//   in_valid/in_ready/x0/x1  : sample handshake from the pin wrapper
//   out_valid/out_ready/y/hidden : result handshake to the consumer
//   cfg_we/cfg_addr/cfg_wdata/cfg_err : config bank write port
//   busy                     : scheduler is not idle
// Modports: master = wrapper/consumer side, slave = scheduler side.
interface neuron_seq_sched_if #(
  parameter int unsigned XW   = 4,
  parameter int unsigned ACCW = 10
);
  logic            in_valid;
  logic            in_ready;
  logic [XW-1:0]   x0;
  logic [XW-1:0]   x1;
  logic            out_valid;
  logic            out_ready;
  logic            y;
  logic [1:0]      hidden;
  logic            cfg_we;
  logic [3:0]      cfg_addr;
  logic [ACCW-1:0] cfg_wdata;
  logic            cfg_err;
  logic            busy;

  modport master (
    output in_valid, x0, x1, out_ready, cfg_we, cfg_addr, cfg_wdata,
    input  in_ready, out_valid, y, hidden, cfg_err, busy
  );

  modport slave (
    input  in_valid, x0, x1, out_ready, cfg_we, cfg_addr, cfg_wdata,
    output in_ready, out_valid, y, hidden, cfg_err, busy
  );
endinterface

// File: rtl/neuron_seq_sched.sv
// Time-multiplexed scheduler for a 2-2-1 threshold-neuron network. One shared
// multiply-accumulate/compare unit evaluates H0, H1 and then O, one per cycle.
// Per-neuron W0/W1/BIAS/THRESH live in a config bank writable while idle.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset (also restores config defaults)
//   bus_io  : slave side of neuron_seq_sched_if (sample in, result out, config)
module neuron_seq_sched #(
  parameter int unsigned XW   = 4,
  parameter int unsigned WW   = 4,
  parameter int unsigned ACCW = 10
) (
  input logic               clk,
  input logic               rst_n,
  neuron_seq_sched_if.slave bus_io
);
  // One spare bit so W0*a + W1*b + BIAS never wraps.
  localparam int unsigned SW = ACCW + 1;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StEvalH0 = 3'd1;
  localparam logic [2:0] StEvalH1 = 3'd2;
  localparam logic [2:0] StEvalO  = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [XW-1:0] x0_q, x0_d, x1_q, x1_d;
  logic          h0_q, h0_d, h1_q, h1_d, y_q, y_d;
  logic [1:0]    hidden_q, hidden_d;
  logic          out_valid_q, out_valid_d;
  logic          cfg_err_q, cfg_err_d;

  // Config bank, index 0=H0, 1=H1, 2=O.
  logic [WW-1:0]   w0_q     [3];
  logic [WW-1:0]   w1_q     [3];
  logic [ACCW-1:0] bias_q   [3];
  logic [ACCW-1:0] thresh_q [3];

  logic          cfg_ok;
  logic [1:0]    cfg_neuron, cfg_field;
  logic [1:0]    sel;
  logic [XW-1:0] op_a, op_b;
  logic [SW-1:0] sum;
  logic          fire;

  assign cfg_neuron = bus_io.cfg_addr[3:2];
  assign cfg_field  = bus_io.cfg_addr[1:0];
  assign cfg_ok     = bus_io.cfg_we && (state_q == StIdle) && (cfg_neuron != 2'd3);
  assign cfg_err_d  = bus_io.cfg_we && !cfg_ok;

  // Shared MAC/compare datapath: operands and coefficients picked by state.
  always_comb begin
    sel  = 2'd0;
    op_a = x0_q;
    op_b = x1_q;
    case (state_q)
      StEvalH1: sel = 2'd1;
      StEvalO: begin
        sel  = 2'd2;
        op_a = {{(XW-1){1'b0}}, h0_q};
        op_b = {{(XW-1){1'b0}}, h1_q};
      end
      default: sel = 2'd0;
    endcase
    sum  = {{(SW-WW){1'b0}}, w0_q[sel]} * {{(SW-XW){1'b0}}, op_a}
         + {{(SW-WW){1'b0}}, w1_q[sel]} * {{(SW-XW){1'b0}}, op_b}
         + {1'b0, bias_q[sel]};
    fire = (sum >= {1'b0, thresh_q[sel]});
  end

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    h0_d        = h0_q;
    h1_d        = h1_q;
    y_d         = y_q;
    hidden_d    = hidden_q;
    out_valid_d = out_valid_q;
    case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          x0_d    = bus_io.x0;
          x1_d    = bus_io.x1;
          state_d = StEvalH0;
        end
      end
      StEvalH0: begin
        h0_d    = fire;
        state_d = StEvalH1;
      end
      StEvalH1: begin
        h1_d    = fire;
        state_d = StEvalO;
      end
      StEvalO: begin
        y_d         = fire;
        hidden_d    = {h1_q, h0_q};
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (bus_io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      x0_q        <= '0;
      x1_q        <= '0;
      h0_q        <= 1'b0;
      h1_q        <= 1'b0;
      y_q         <= 1'b0;
      hidden_q    <= 2'b00;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      h0_q        <= h0_d;
      h1_q        <= h1_d;
      y_q         <= y_d;
      hidden_q    <= hidden_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w0_q[0] <= WW'(2);  w1_q[0] <= WW'(1);  bias_q[0] <= ACCW'(1);  thresh_q[0] <= ACCW'(6);
      w0_q[1] <= WW'(1);  w1_q[1] <= WW'(3);  bias_q[1] <= ACCW'(2);  thresh_q[1] <= ACCW'(10);
      w0_q[2] <= WW'(2);  w1_q[2] <= WW'(2);  bias_q[2] <= ACCW'(0);  thresh_q[2] <= ACCW'(2);
    end else if (cfg_ok) begin
      unique case (cfg_field)
        2'd0: w0_q[cfg_neuron]     <= bus_io.cfg_wdata[WW-1:0];
        2'd1: w1_q[cfg_neuron]     <= bus_io.cfg_wdata[WW-1:0];
        2'd2: bias_q[cfg_neuron]   <= bus_io.cfg_wdata;
        2'd3: thresh_q[cfg_neuron] <= bus_io.cfg_wdata;
        default: ;
      endcase
    end
  end

  assign bus_io.in_ready  = (state_q == StIdle);
  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.y         = y_q;
  assign bus_io.hidden    = hidden_q;
  assign bus_io.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_neuron_seq_sched.sv
// Self-checking bench for neuron_seq_sched: a table of default-config samples
// plus directed sequences for config writes, output stall, bad address and
// reset in mid-evaluation. Inputs change and outputs are sampled on negedge.
`timescale 1ns/1ps
module tb_neuron_seq_sched;
  localparam int unsigned XW   = 4;
  localparam int unsigned WW   = 4;
  localparam int unsigned ACCW = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  neuron_seq_sched_if #(.XW(XW), .ACCW(ACCW)) bus ();

  neuron_seq_sched #(.XW(XW), .WW(WW), .ACCW(ACCW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  typedef struct packed {
    logic [3:0] x0;
    logic [3:0] x1;
    logic [1:0] hid;
    logic       y;
  } vec_t;

  vec_t vecs [10];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Starts at a negedge in IDLE. The accept edge counts as edge 1; the result
  // must appear after edge 4. Leaves the bench at a negedge back in IDLE.
  task automatic run_sample(input logic [3:0] a, input logic [3:0] b,
                            input logic [1:0] eh, input logic ey, input string name);
    int lat;
    bit got;
    check({name, ".in_ready"}, 32'(bus.in_ready), 1);
    bus.x0       = a;
    bus.x1       = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.x0       = 4'hf;  // must be ignored after the accept edge
    bus.x1       = 4'hf;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({name, ".got_result"}, 32'(got), 1);
    check({name, ".latency"}, 32'(lat), 4);
    check({name, ".hidden"}, 32'(bus.hidden), 32'(eh));
    check({name, ".y"}, 32'(bus.y), 32'(ey));
    @(posedge clk);
    @(negedge clk);
    check({name, ".out_valid_clr"}, 32'(bus.out_valid), 0);
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [9:0] data,
                           input logic exp_err, input string name);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = data;
    @(posedge clk);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    check({name, ".cfg_err"}, 32'(bus.cfg_err), 32'(exp_err));
    @(posedge clk);
    @(negedge clk);
    check({name, ".cfg_err_pulse"}, 32'(bus.cfg_err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{x0: 4'd3,  x1: 4'd0,  hid: 2'b01, y: 1'b1};
    vecs[1] = '{x0: 4'd0,  x1: 4'd0,  hid: 2'b00, y: 1'b0};
    vecs[2] = '{x0: 4'd15, x1: 4'd15, hid: 2'b11, y: 1'b1};  // H1 sum 62, no wrap
    vecs[3] = '{x0: 4'd0,  x1: 4'd3,  hid: 2'b10, y: 1'b1};
    vecs[4] = '{x0: 4'd2,  x1: 4'd2,  hid: 2'b11, y: 1'b1};  // H1 sum == THRESH
    vecs[5] = '{x0: 4'd1,  x1: 4'd2,  hid: 2'b00, y: 1'b0};
    vecs[6] = '{x0: 4'd2,  x1: 4'd1,  hid: 2'b01, y: 1'b1};  // H0 sum == THRESH
    vecs[7] = '{x0: 4'd1,  x1: 4'd1,  hid: 2'b00, y: 1'b0};
    vecs[8] = '{x0: 4'd0,  x1: 4'd2,  hid: 2'b00, y: 1'b0};
    vecs[9] = '{x0: 4'd4,  x1: 4'd2,  hid: 2'b11, y: 1'b1};

    bus.in_valid  = 1'b0;
    bus.x0        = '0;
    bus.x1        = '0;
    bus.out_ready = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;

    #12;
    check("reset.in_ready", 32'(bus.in_ready), 1);
    check("reset.out_valid", 32'(bus.out_valid), 0);
    check("reset.y", 32'(bus.y), 0);
    check("reset.hidden", 32'(bus.hidden), 0);
    check("reset.cfg_err", 32'(bus.cfg_err), 0);
    check("reset.busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_sample(vecs[i].x0, vecs[i].x1, vecs[i].hid, vecs[i].y, $sformatf("vec%0d", i));
    end

    // H0.THRESH=8 written in IDLE: H0 sum 7 no longer fires.
    cfg_write(4'b0011, 10'd8, 1'b0, "wr_h0_thr");
    run_sample(4'd3, 4'd0, 2'b00, 1'b0, "h0_thr8");
    cfg_write(4'b0011, 10'd6, 1'b0, "restore_h0_thr");

    // Same write on the accept edge must already apply to that sample.
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 4'b0011;
    bus.cfg_wdata = 10'd8;
    run_sample(4'd3, 4'd0, 2'b00, 1'b0, "h0_thr8_same_edge");
    check("same_edge.cfg_err", 32'(bus.cfg_err), 0);
    cfg_write(4'b0011, 10'd6, 1'b0, "restore_h0_thr2");

    // O.THRESH=3: H0 alone gives O sum 2.
    cfg_write(4'b1011, 10'd3, 1'b0, "wr_o_thr");
    run_sample(4'd3, 4'd0, 2'b01, 1'b0, "o_thr3");
    cfg_write(4'b1011, 10'd2, 1'b0, "restore_o_thr");

    // Weight writes keep only the low bits: H1.W1 becomes 0.
    cfg_write(4'b0101, 10'h3f0, 1'b0, "wr_h1_w1");
    run_sample(4'd0, 4'd15, 2'b01, 1'b1, "h1_w1_zero");
    cfg_write(4'b0101, 10'd3, 1'b0, "restore_h1_w1");

    // Output stall with a config write attempted during DONE.
    bus.out_ready = 1'b0;
    bus.x0        = 4'd3;
    bus.x1        = 4'd0;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.out_valid; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("stall.out_valid_rise", 32'(bus.out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("stall%0d.out_valid", i), 32'(bus.out_valid), 1);
      check($sformatf("stall%0d.hidden", i), 32'(bus.hidden), 32'(2'b01));
      check($sformatf("stall%0d.y", i), 32'(bus.y), 1);
      check($sformatf("stall%0d.in_ready", i), 32'(bus.in_ready), 0);
      check($sformatf("stall%0d.busy", i), 32'(bus.busy), 1);
      if (i == 3) begin
        cfg_write(4'b0011, 10'd15, 1'b1, "stall_cfg");
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall_release.out_valid", 32'(bus.out_valid), 0);
    check("stall_release.in_ready", 32'(bus.in_ready), 1);
    check("stall_release.hidden_hold", 32'(bus.hidden), 32'(2'b01));
    run_sample(4'd3, 4'd0, 2'b01, 1'b1, "after_dropped_cfg");

    // Invalid neuron address while idle.
    cfg_write(4'b1100, 10'd0, 1'b1, "bad_addr");
    check("bad_addr.hidden_hold", 32'(bus.hidden), 32'(2'b01));
    check("bad_addr.y_hold", 32'(bus.y), 1);
    check("bad_addr.in_ready", 32'(bus.in_ready), 1);
    run_sample(4'd0, 4'd3, 2'b10, 1'b1, "after_bad_addr");

    // Reset during EVAL_H1 with a modified config.
    cfg_write(4'b0011, 10'd8, 1'b0, "pre_reset_cfg");
    bus.x0       = 4'd3;
    bus.x1       = 4'd0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset.out_valid", 32'(bus.out_valid), 0);
    check("mid_reset.in_ready", 32'(bus.in_ready), 1);
    check("mid_reset.busy", 32'(bus.busy), 0);
    check("mid_reset.hidden", 32'(bus.hidden), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sample(4'd3, 4'd0, 2'b01, 1'b1, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
